frame_commit_buffer: RTL
========================

Name: frame_commit_buffer

Overview:
- Sits between the 32-bit word aggregator and the debug core's bus input (addr/wdata/rw/valid) on the 50 MHz Ethernet clock.
- Buffers the aggregated words of each received frame until the frame-check result arrives.
- On a good frame it releases the words as bus writes, one per pacing slot. On a bad or overrun frame it discards every word of that frame.
- This keeps corrupted Ethernet frames from reaching the register space.

Parameters:
- DEPTH, 16, buffer capacity in 32-bit words; power of two, at least 2.
- GAP, 0, minimum idle cycles between consecutive bus_valid pulses.
- CNT_W, 8, width of the dropped-frame counter.

Ports:
- clk  input  1  Ethernet-domain clock (50 MHz).
- rstn  input  1  asynchronous active-low reset.
- axiiv  input  1  aggregated word valid, single-cycle per word.
- axiid  input  32  aggregated word: [31:16] = address, [15:0] = write data.
- fcs_done  input  1  single-cycle pulse at frame end: frame check passed.
- fcs_kill  input  1  single-cycle pulse at frame end: frame check failed.
- bus_addr  output  16  write address to debug core.
- bus_wdata  output  16  write data to debug core.
- bus_rw  output  1  constant 1 (write).
- bus_valid  output  1  single-cycle write strobe.
- overflow  output  1  sticky; set when a word arrives while the buffer is full.
- drop_count  output  CNT_W  number of discarded frames; saturates at all-ones.

Behaviour:
- Reset (asynchronous, rstn low):
  - All pointers, the FSM, the gap counter, overflow and drop_count clear to 0.
  - bus_addr, bus_wdata and bus_valid drive 0; bus_rw drives 1.
  - Reset mid-frame or mid-drain loses all buffered data; no partial output follows.
- Storage:
  - Circular RAM of DEPTH x 32 bits.
  - Pointers are log2(DEPTH)+1 bits wide: wr_ptr (next write), cmt_ptr (end of committed data), rd_ptr (next read).
  - full = (wr_ptr - rd_ptr) == DEPTH.
  - committed-nonempty = rd_ptr != cmt_ptr.
- Write FSM states: IDLE, FILL, OVERRUN.
  - IDLE: an axiiv word is written at wr_ptr and wr_ptr increments; go to FILL. If full, go directly to OVERRUN instead and do not write.
  - FILL: axiiv writes as in IDLE; an axiiv while full goes to OVERRUN and sets overflow.
  - OVERRUN: all further axiiv words are ignored.
- Frame end (fcs_done or fcs_kill):
  - fcs_done in IDLE/FILL: cmt_ptr <= wr_ptr. A word written in the same cycle is included in the commit. Go to IDLE.
  - fcs_kill in any state, or fcs_done in OVERRUN: wr_ptr <= cmt_ptr. A same-cycle word is discarded. drop_count increments with saturation. Go to IDLE.
  - fcs_done and fcs_kill asserted together: treated as kill.
  - fcs_done in IDLE with no words written: no pointer change, no count.
- Read side:
  - When committed-nonempty and the gap counter is 0: register RAM[rd_ptr] onto bus_addr/bus_wdata, assert bus_valid for exactly 1 cycle, increment rd_ptr, and load the gap counter with GAP.
  - The gap counter decrements to 0 on each cycle with no strobe.
  - bus_addr and bus_wdata hold their last value while bus_valid is low.
- Latency:
  - The first word of a committed frame shows bus_valid 2 cycles after the fcs_done cycle (1 cycle commit, 1 cycle RAM read/register).
  - Back-to-back words follow every GAP+1 cycles.
- Concurrency:
  - Reads and writes proceed in the same cycle.
  - Read-side space freed this cycle is visible to full on the next cycle.
  - Pointer wrap-around is handled by the extra MSB; there is no special case at DEPTH boundaries.
- Ordering: words leave in arrival order, and no frame ever interleaves with another.

Decomposition:
- Package frame_commit_pkg holds:
  - the wr_state_t enum {IDLE, FILL, OVERRUN};
  - localparams for the address/data field slices (ADDR_HI=31, ADDR_LO=16, DATA_HI=15, DATA_LO=0).
- Sub-module fcb_ram: a simple dual-port DEPTH x 32 RAM with one registered read port, so it infers as distributed/block RAM.
- FSM, pointers and pacing stay in the top of this block.

Test Plan:
- Good frame: 3 words 0x0001_AAAA, 0x0002_BBBB, 0x0003_CCCC, then fcs_done -> 3 bus_valid pulses with GAP=0, addr 1/2/3 and wdata AAAA/BBBB/CCCC. The first pulse comes 2 cycles after fcs_done; drop_count=0.
- Bad frame: 4 words then fcs_kill -> no bus_valid, drop_count=1. A following good 1-word frame 0x0010_1234 emits exactly addr 0x0010, wdata 0x1234.
- Overrun (DEPTH=16): 17 words, then fcs_done -> overflow=1, drop_count=1, no bus_valid. The next good frame is emitted normally; overflow stays 1 until reset.
- Simultaneous events: the last word arrives in the same cycle as fcs_done -> that word is emitted (4 words in, 4 out). The same setup with fcs_done and fcs_kill together -> 0 out, drop_count+1.
- Pacing/wrap (GAP=3): 10 good frames of 5 words each, streamed so the pointers wrap -> 50 pulses in order, each at least 4 cycles apart, no loss.
- Reset mid-drain: rstn low while 3 words are pending -> all outputs 0 immediately. After release, no pulses until a new committed frame arrives.

Source files
------------

// File: rtl/frame_commit_pkg.sv
// Shared types and field slices for the frame commit buffer.
// Word layout: [31:16] bus address, [15:0] write data.
package frame_commit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    OVERRUN = 2'd2
  } wr_state_t;

  localparam int ADDR_HI = 31;
  localparam int ADDR_LO = 16;
  localparam int DATA_HI = 15;
  localparam int DATA_LO = 0;

endpackage

// File: rtl/fcb_ram.sv
// Simple dual-port DEPTH x 32 RAM, one write port, one registered read port.
// The read register holds its value when no read is requested.
module fcb_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/frame_commit_buffer.sv
// Holds each frame's words until its FCS verdict; releases good frames
// as paced bus writes and rolls back bad or overrun frames.
module frame_commit_buffer
  import frame_commit_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int GAP   = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             axiiv,
  input  logic [31:0]      axiid,
  input  logic             fcs_done,
  input  logic             fcs_kill,
  output logic [15:0]      bus_addr,
  output logic [15:0]      bus_wdata,
  output logic             bus_rw,
  output logic             bus_valid,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_cmt_ptr;
  logic [PW-1:0]    r_rd_ptr;
  wr_state_t        r_state;
  logic [GW-1:0]    r_gap;
  logic             r_valid;
  logic             r_overflow;
  logic [CNT_W-1:0] r_drop;

  logic          w_full;
  logic          w_ovr;
  logic          w_hit_full;
  logic          w_kill;
  logic          w_commit;
  logic          w_wr_en;
  logic          w_rd_en;
  logic [PW-1:0] w_wr_next;
  logic [31:0]   w_rdata;

  assign w_full     = (r_wr_ptr - r_rd_ptr) == PW'(DEPTH);
  assign w_ovr      = (r_state == OVERRUN);
  assign w_hit_full = axiiv & w_full & ~w_ovr;

  // A frame that lost a word to a full buffer can never commit.
  assign w_kill   = fcs_kill | (fcs_done & (w_ovr | w_hit_full));
  assign w_commit = fcs_done & ~w_kill;

  assign w_wr_en   = axiiv & ~w_full & ~w_ovr & ~w_kill;
  assign w_wr_next = r_wr_ptr + PW'(w_wr_en);

  assign w_rd_en = (r_rd_ptr != r_cmt_ptr) & (r_gap == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_wr_ptr  <= '0;
      r_cmt_ptr <= '0;
      r_drop    <= '0;
    end else if (w_kill) begin
      r_state  <= IDLE;
      r_wr_ptr <= r_cmt_ptr;
      if (r_drop != '1) r_drop <= r_drop + 1'b1;
    end else if (w_commit) begin
      r_state   <= IDLE;
      r_wr_ptr  <= w_wr_next;
      r_cmt_ptr <= w_wr_next;
    end else begin
      unique case (r_state)
        IDLE, FILL: begin
          r_wr_ptr <= w_wr_next;
          if (w_hit_full)   r_state <= OVERRUN;
          else if (w_wr_en) r_state <= FILL;
        end
        OVERRUN: r_state <= OVERRUN;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)           r_overflow <= 1'b0;
    else if (w_hit_full) r_overflow <= 1'b1;
  end

  // Pacing: a strobe reloads the gap counter, idle cycles drain it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_ptr <= '0;
      r_gap    <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_rd_en;
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_gap    <= GW'(GAP);
      end else if (r_gap != '0) begin
        r_gap <= r_gap - 1'b1;
      end
    end
  end

  fcb_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rstn    (rstn),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (axiid),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  assign bus_addr   = w_rdata[ADDR_HI:ADDR_LO];
  assign bus_wdata  = w_rdata[DATA_HI:DATA_LO];
  assign bus_rw     = 1'b1;
  assign bus_valid  = r_valid;
  assign overflow   = r_overflow;
  assign drop_count = r_drop;

endmodule
